hier_fanout_node: RTL and testbench
===================================

// Module: hier_fanout_node
// PURPOSE
//  Parametrised hierarchy node that fans one upstream request out to NUM_CHILD child
//  sub-modules and merges their responses into a single upstream response.
//  Replaces the fixed, portless 5-child hierarchy nodes with a generic node.
//  It adds a valid/ready handshake, a per-request child-select mask, response merging
//  and a timeout, so that any level of the hierarchy tree is built from one block.
// PARAMETERS
//  NUM_CHILD  5   number of child ports (>=1)
//  DATA_W     16  request/response data width
//  TIMEOUT    64  cycles allowed in ISSUE+COLLECT before abort (>=2)
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst_n          in   1                 asynchronous active-low reset
//  req_valid      in   1                 upstream request valid
//  req_ready      out  1                 node accepts request (IDLE only)
//  req_mask       in   NUM_CHILD         children addressed by this request
//  req_data       in   DATA_W            request payload, broadcast to children
//  ch_valid       out  NUM_CHILD         per-child request valid
//  ch_ready       in   NUM_CHILD         per-child request ready
//  ch_data        out  DATA_W            latched payload, shared by all children
//  ch_rsp_valid   in   NUM_CHILD         per-child response strobe (single cycle)
//  ch_rsp_data    in   NUM_CHILD*DATA_W  child i response in bits [i*DATA_W +: DATA_W]
//  rsp_valid      out  1                 upstream response valid
//  rsp_ready      in   1                 upstream response ready
//  rsp_data       out  DATA_W            XOR of accepted child responses
//  rsp_ack_mask   out  NUM_CHILD         children whose response was accepted
//  rsp_timeout    out  1                 response was produced by timeout abort
//  busy           out  1                 FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM to IDLE; all outputs 0 except req_ready=1.
//   ch_data, the accumulators and the timer are cleared.
//   Reset mid-operation abandons the request; ch_valid drops immediately.
//  FSM states: IDLE, ISSUE, COLLECT, RESPOND.
//  IDLE: req_ready=1. On req_valid:
//   - Latch req_data into ch_data.
//   - Set pend_iss=pend_rsp=req_mask; clear acc, ack_mask and timer.
//   - Go to ISSUE; if req_mask==0, go directly to RESPOND with data 0, ack 0, timeout 0.
//  ISSUE: ch_valid=pend_iss.
//   - Bit i clears on ch_valid[i]&ch_ready[i]; valid and data are held stable until then.
//   - Go to COLLECT when pend_iss becomes 0.
//  Response accept (in ISSUE and COLLECT):
//   - Child i is accepted when ch_rsp_valid[i] & pend_rsp[i] & ~pend_iss[i].
//   - pend_iss is the registered value, so a response never counts in its own issue cycle.
//   - On accept: acc ^= child data; ack_mask[i]=1; pend_rsp[i]=0.
//   - Several children may be accepted in the same cycle; all are XORed in.
//   - Unsolicited responses, duplicates and responses from unissued children are ignored.
//  COLLECT: go to RESPOND when pend_rsp becomes 0.
//  Timer: increments every cycle in ISSUE/COLLECT.
//   - If timer==TIMEOUT-1 and work is still pending after that cycle's updates:
//     go to RESPOND with rsp_timeout=1 and ch_valid forced to 0.
//   - If all work completes in that same cycle, the response is a normal one (timeout=0).
//  RESPOND: rsp_valid=1; rsp_data, rsp_ack_mask and rsp_timeout are stable.
//   - Return to IDLE on rsp_ready; req_ready=0 until then.
//  Minimum latency: request accepted at cycle 0, child handshake at cycle 1,
//   response accepted at cycle 2, rsp_valid at cycle 3.
//  busy = (state != IDLE). The node handles one request at a time; there is no queuing.
// TESTING
//  T1 NUM_CHILD=5; mask=5'b00101, data=0x1234; ch0/ch2 ready at once and respond
//     0x000F/0x00F0 at cycle 2 -> ch_data=0x1234; rsp_valid at cycle 3;
//     rsp_data=0x00FF, ack=00101, timeout=0.
//  T2 mask=0 -> rsp_valid at cycle 1; data=0, ack=0, timeout=0; no ch_valid ever asserted.
//  T3 mask=5'b01001; ch3 ready but never responds; TIMEOUT=64 -> rsp_valid at cycle 65;
//     timeout=1; ack=00001; ch3 valid low from cycle 65.
//  T4 ch1 ready held low 5 cycles -> ch_valid[1] and ch_data stable all 5 cycles;
//     rsp_ready low 10 cycles -> response held stable; req_ready=0 throughout.
//  T5 mask=5'b00010; ch4 pulses rsp 0xFFFF; ch1 pulses rsp twice (0x0001 then 0x0002)
//     -> rsp_data=0x0001, ack=00010.
//  T6 rst_n low during ISSUE -> outputs 0 and req_ready=1 asynchronously;
//     the next request (T1 stimulus) gives T1 results.

Source files
------------

// File: rtl/hier_fanout_node_if.sv
// hier_fanout_node_if
//  Bundles the upstream request/response handshake and the per-child request and
//  response buses of one hierarchy node.
//  master : the side that issues upstream requests and plays the children
//           (the parent level, or a testbench)
//  slave  : the hierarchy node itself
//  Signals
//   req_valid/req_ready/req_mask/req_data          upstream request
//   ch_valid/ch_ready/ch_data                      fan-out to children
//   ch_rsp_valid/ch_rsp_data                       child responses, child i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready/rsp_data/rsp_ack_mask/rsp_timeout   merged upstream response
//   busy                                           node is working on a request
interface hier_fanout_node_if #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16
);
    logic                        req_valid;
    logic                        req_ready;
    logic [NUM_CHILD-1:0]        req_mask;
    logic [DATA_W-1:0]           req_data;
    logic [NUM_CHILD-1:0]        ch_valid;
    logic [NUM_CHILD-1:0]        ch_ready;
    logic [DATA_W-1:0]           ch_data;
    logic [NUM_CHILD-1:0]        ch_rsp_valid;
    logic [NUM_CHILD*DATA_W-1:0] ch_rsp_data;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_W-1:0]           rsp_data;
    logic [NUM_CHILD-1:0]        rsp_ack_mask;
    logic                        rsp_timeout;
    logic                        busy;

    modport master (
        output req_valid, req_mask, req_data, ch_ready, ch_rsp_valid, ch_rsp_data, rsp_ready,
        input  req_ready, ch_valid, ch_data, rsp_valid, rsp_data, rsp_ack_mask, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_mask, req_data, ch_ready, ch_rsp_valid, ch_rsp_data, rsp_ready,
        output req_ready, ch_valid, ch_data, rsp_valid, rsp_data, rsp_ack_mask, rsp_timeout, busy
    );
endinterface

// File: rtl/hier_fanout_node.sv
// hier_fanout_node
//  Generic hierarchy node: takes one upstream request, issues it to the children
//  selected by req_mask, XOR-merges their responses and returns one upstream
//  response. A timer aborts the request if the children do not finish within
//  TIMEOUT cycles of ISSUE+COLLECT. One request is handled at a time.
//  Ports
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hier_fanout_node_if.slave (request, child fan-out, child responses,
//          merged response, busy)
module hier_fanout_node #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    hier_fanout_node_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESPOND} state_t;

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    ch_data_q;
    logic [NUM_CHILD-1:0] pend_iss, pend_rsp;
    logic [NUM_CHILD-1:0] pend_iss_nxt, pend_rsp_nxt;
    logic [NUM_CHILD-1:0] ch_valid_c, accept;
    logic [DATA_W-1:0]    acc, acc_nxt;
    logic [NUM_CHILD-1:0] ack_mask;
    logic [TW-1:0]        timer;
    logic                 timeout_q, timeout_set;
    logic                 working;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the per-cycle handshake/accept terms.
    // A response is accepted only once the child's issue handshake is already in
    // the registered pend_iss, so a response never counts in its own issue cycle.
    // "Still pending" after the updates is pend_rsp_nxt != 0, because every child
    // still awaiting issue is also still awaiting a response.
    always_comb begin
        working      = (state == ISSUE) || (state == COLLECT);
        ch_valid_c   = (state == ISSUE) ? pend_iss : '0;
        pend_iss_nxt = pend_iss & ~(ch_valid_c & bus.ch_ready);
        accept       = working ? (bus.ch_rsp_valid & pend_rsp & ~pend_iss) : '0;
        pend_rsp_nxt = pend_rsp & ~accept;
        acc_nxt      = acc;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (accept[i]) begin
                acc_nxt = acc_nxt ^ bus.ch_rsp_data[i*DATA_W +: DATA_W];
            end
        end
        state_nxt   = state;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (bus.req_mask == '0) ? RESPOND : ISSUE;
                end
            end
            ISSUE: begin
                if (pend_iss_nxt == '0) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (pend_rsp_nxt == '0) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (working && (timer == TW'(TIMEOUT - 1)) && (pend_rsp_nxt != '0)) begin
            state_nxt   = RESPOND;
            timeout_set = 1'b1;
        end
    end

    // Datapath: request latch on acceptance, pending masks, accumulator and timer
    // while working. Everything holds in RESPOND so the response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data_q <= '0;
            pend_iss  <= '0;
            pend_rsp  <= '0;
            acc       <= '0;
            ack_mask  <= '0;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ch_data_q <= bus.req_data;
                        pend_iss  <= bus.req_mask;
                        pend_rsp  <= bus.req_mask;
                        acc       <= '0;
                        ack_mask  <= '0;
                        timer     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ISSUE, COLLECT: begin
                    pend_iss  <= pend_iss_nxt;
                    pend_rsp  <= pend_rsp_nxt;
                    acc       <= acc_nxt;
                    ack_mask  <= ack_mask | accept;
                    timer     <= timer + TW'(1);
                    timeout_q <= timeout_set;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        bus.req_ready    = (state == IDLE);
        bus.busy         = (state != IDLE);
        bus.ch_valid     = ch_valid_c;
        bus.ch_data      = ch_data_q;
        bus.rsp_valid    = (state == RESPOND);
        bus.rsp_data     = acc;
        bus.rsp_ack_mask = ack_mask;
        bus.rsp_timeout  = timeout_q;
    end

endmodule

// File: tb/tb_hier_fanout_node.sv
// tb_hier_fanout_node
//  Directed bench for hier_fanout_node (NUM_CHILD=5, DATA_W=16, TIMEOUT=64).
//  The stimulus thread issues requests and plays the children; each request pushes
//  its hand-computed response (data, ack mask, timeout flag, arrival cycle) into a
//  queue that an independent monitor pops whenever the node presents a response.
//  Cycle numbering: cycle 1 starts at the clock edge that accepts the request.
module tb_hier_fanout_node;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int TO = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [NC-1:0] ack;
        logic          to;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   seen = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hier_fanout_node_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus();

    hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Monitor: on every falling edge with a response presented, compare it against
    // the head of the queue (arrival cycle once, fields every cycle it is held) and
    // pop it when the upstream side accepts it.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_rsp: rsp_valid=1 data=%h, required no response", bus.rsp_data);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    total++;
                    if (cyc == sb[0].cyc) passed++;
                    else $display("[TB] FAIL rsp_latency: got cycle %0d, required %0d", cyc, sb[0].cyc);
                end
                total++;
                if (bus.rsp_data === sb[0].data && bus.rsp_ack_mask === sb[0].ack &&
                    bus.rsp_timeout === sb[0].to) begin
                    passed++;
                end else begin
                    $display("[TB] FAIL rsp_fields: got data=%h ack=%b to=%b, required data=%h ack=%b to=%b",
                             bus.rsp_data, bus.rsp_ack_mask, bus.rsp_timeout,
                             sb[0].data, sb[0].ack, sb[0].to);
                end
                if (bus.rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.ch_rsp_valid = '0;
    endtask

    task automatic child_rsp(input int i, input logic [DW-1:0] d);
        bus.ch_rsp_valid[i]          = 1'b1;
        bus.ch_rsp_data[i*DW +: DW]  = d;
    endtask

    // Issue one request from IDLE and register the response it must produce,
    // arriving in cycle rsp_cycle. Returns in cycle 1.
    task automatic applyStimulus(input logic [NC-1:0] mask, input logic [DW-1:0] data,
                                 input logic [DW-1:0] e_data, input logic [NC-1:0] e_ack,
                                 input logic e_to, input int rsp_cycle);
        exp_t e;
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_mask  = mask;
        bus.req_data  = data;
        tick();
        bus.req_valid = 1'b0;
        e.data = e_data;
        e.ack  = e_ack;
        e.to   = e_to;
        e.cyc  = cyc + rsp_cycle - 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput("return_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_t1();
        applyStimulus(5'b00101, 16'h1234, 16'h00FF, 5'b00101, 1'b0, 3);
        checkOutput("t1_ch_valid", 32'(bus.ch_valid), 32'h05);
        checkOutput("t1_ch_data", 32'(bus.ch_data), 32'h1234);
        bus.ch_ready = 5'b00101;
        tick();
        bus.ch_ready = '0;
        checkOutput("t1_ch_valid_collect", 32'(bus.ch_valid), 32'h0);
        child_rsp(0, 16'h000F);
        child_rsp(2, 16'h00F0);
        tick();
        wait_idle();
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_mask     = '0;
        bus.req_data     = '0;
        bus.ch_ready     = '0;
        bus.ch_rsp_valid = '0;
        bus.ch_rsp_data  = '0;
        bus.rsp_ready    = 1'b1;
        #12;
        // Reset state: {req_ready,busy,rsp_valid,ch_valid,rsp_ack_mask,rsp_timeout}
        checkOutput("reset_ctrl", 32'({bus.req_ready, bus.busy, bus.rsp_valid, bus.ch_valid,
                                       bus.rsp_ack_mask, bus.rsp_timeout}), 32'h2000);
        checkOutput("reset_data", 32'({bus.ch_data, bus.rsp_data}), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] T1 basic two-child request");
        run_t1();

        $display("[TB] T2 empty mask");
        applyStimulus(5'b00000, 16'hABCD, 16'h0000, 5'b00000, 1'b0, 1);
        checkOutput("t2_ch_valid", 32'(bus.ch_valid), 32'h0);
        wait_idle();

        $display("[TB] T3 issued child never responds");
        applyStimulus(5'b01001, 16'h3333, 16'h0A0A, 5'b00001, 1'b1, 65);
        bus.ch_ready = 5'b01001;
        tick();
        bus.ch_ready = '0;
        child_rsp(0, 16'h0A0A);
        tick();
        for (int k = 3; k < 64; k++) tick();
        checkOutput("t3_pending_c64", 32'({bus.busy, bus.rsp_valid}), 32'h2);
        tick();
        checkOutput("t3_ch_valid_c65", 32'(bus.ch_valid), 32'h0);
        wait_idle();

        $display("[TB] T3b child never ready, valid dropped on abort");
        applyStimulus(5'b01001, 16'h4444, 16'h0B0B, 5'b00001, 1'b1, 65);
        bus.ch_ready = 5'b00001;
        tick();
        bus.ch_ready = '0;
        child_rsp(0, 16'h0B0B);
        tick();
        for (int k = 3; k < 64; k++) tick();
        checkOutput("t3b_ch_valid_c64", 32'(bus.ch_valid), 32'h08);
        tick();
        checkOutput("t3b_ch_valid_c65", 32'(bus.ch_valid), 32'h0);
        wait_idle();

        $display("[TB] T3c completion in the last allowed cycle");
        applyStimulus(5'b00001, 16'h5555, 16'h0C0C, 5'b00001, 1'b0, 65);
        bus.ch_ready = 5'b00001;
        tick();
        bus.ch_ready = '0;
        for (int k = 2; k < 64; k++) tick();
        child_rsp(0, 16'h0C0C);
        tick();
        wait_idle();

        $display("[TB] T4 child backpressure and response held");
        bus.rsp_ready = 1'b0;
        applyStimulus(5'b00010, 16'hBEEF, 16'h5555, 5'b00010, 1'b0, 8);
        for (int k = 1; k <= 5; k++) begin
            checkOutput("t4_ch_valid_held", 32'(bus.ch_valid), 32'h02);
            checkOutput("t4_ch_data_held", 32'(bus.ch_data), 32'hBEEF);
            checkOutput("t4_req_ready_busy", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.ch_ready = 5'b00010;
        tick();
        bus.ch_ready = '0;
        child_rsp(1, 16'h5555);
        tick();
        for (int k = 0; k < 10; k++) begin
            checkOutput("t4_req_ready_respond", 32'(bus.req_ready), 32'd0);
            tick();
        end
        wait_idle();

        $display("[TB] T5 unsolicited, same-cycle and duplicate responses");
        applyStimulus(5'b00010, 16'h0042, 16'h0001, 5'b00010, 1'b0, 3);
        bus.ch_ready = 5'b00010;
        child_rsp(4, 16'hFFFF);
        child_rsp(1, 16'h7777);
        tick();
        bus.ch_ready = '0;
        child_rsp(1, 16'h0001);
        child_rsp(4, 16'hFFFF);
        tick();
        child_rsp(1, 16'h0002);
        wait_idle();

        $display("[TB] T7 simultaneous accepts, duplicate and unissued child");
        applyStimulus(5'b11010, 16'h7007, 16'h4311, 5'b11010, 1'b0, 4);
        bus.ch_ready = 5'b11010;
        tick();
        bus.ch_ready = '0;
        child_rsp(1, 16'h0011);
        child_rsp(3, 16'h0300);
        tick();
        child_rsp(1, 16'hFFFF);
        child_rsp(0, 16'h1111);
        child_rsp(4, 16'h4000);
        tick();
        wait_idle();

        $display("[TB] T6 asynchronous reset during ISSUE");
        bus.req_valid = 1'b1;
        bus.req_mask  = 5'b00101;
        bus.req_data  = 16'h9999;
        tick();
        bus.req_valid = 1'b0;
        checkOutput("t6_ch_valid_before", 32'(bus.ch_valid), 32'h05);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_ctrl", 32'({bus.req_ready, bus.busy, bus.rsp_valid, bus.ch_valid,
                                          bus.rsp_ack_mask, bus.rsp_timeout}), 32'h2000);
        checkOutput("t6_reset_data", 32'({bus.ch_data, bus.rsp_data}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_t1();

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
